sseg_arb: RTL and testbench
===========================

Name: sseg_arb

Overview:
- Round-robin arbiter sharing the single 8-digit seven-segment display between NREQ requesters, e.g. status, error code and debug value.
- Drives the en / mod / dat inputs of the seven-segment driver.
- Each granted requester owns the display for at least a minimum hold time. After that it yields if another requester is waiting.
- Sits between system-level sources and the display driver at top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD, 100000000, minimum ownership time in clk cycles (>=2); 1 s at 100 MHz.
- CNT_W, $clog2(HOLD), hold counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset. Synchronous, active-high, one clock.
- req, input, NREQ, per-requester display request. Level, held while display wanted.
- dat_i, input, 32*NREQ, requester k value at bits [32k+31:32k].
- blink_i, input, NREQ, requester k wants blink mode.
- gnt, output, NREQ, one-hot current owner (registered); all-zero when none.
- en, output, 1, display enable to driver; equals |gnt.
- mod, output, 1, blink select to driver; equals blink_i[owner], 0 when no owner.
- dat, output, 32, value to driver; equals dat_i slice of owner, 32'h0 when no owner.

Behaviour:
- Reset values: gnt=0, en=0, mod=0, dat=0, state=IDLE, ptr=0, cnt=0. Reset mid-HOLD aborts ownership at the next edge.
- Registered state is gnt, state, ptr (round-robin start index, 0..NREQ-1) and cnt.
- en, mod and dat are combinational from gnt, blink_i and dat_i. Data and blink changes of the owner pass through with zero latency.
- RR pick: first set bit of a candidate vector scanning ptr, ptr+1, … and wrapping modulo NREQ.
- IDLE state:
  - If |req: gnt <= onehot(pick(req)), ptr <= (winner+1) mod NREQ, cnt <= HOLD-1, go to HOLD.
  - Else stay.
  - Grant latency is 1 cycle from req sampled high.
- HOLD state, priority order:
  1. If req[owner]==0: gnt <= 0, go to IDLE. The display is blank for at least one cycle. Early release is allowed before hold expiry.
  2. Else if cnt!=0: cnt <= cnt-1.
  3. Else (hold expired): if |(req & ~gnt), switch gnt to pick(req & ~gnt), update ptr, cnt <= HOLD-1, stay in HOLD. The switch takes no gap cycle.
  4. Else (no other waiter): keep owner, cnt <= HOLD-1.
- A requester held continuously owns the display for exactly HOLD cycles per turn when others are waiting.
- Requests arriving mid-hold are not seen until expiry; there is no preemption.
- Simultaneous owner drop and hold expiry: the drop wins and the block goes to IDLE.
- Never more than one gnt bit set. Bits of gnt outside 0..NREQ-1 do not exist.
- ptr wraps from NREQ-1 to 0.
- Width rules:
  - cnt is CNT_W bits and never underflows; reload is HOLD-1.
  - dat_i slicing is by owner index. Out-of-range or unknown owner yields 32'h0.

Decomposition:
- Shared package sseg_pkg holds:
  - state encoding (IDLE=1'b0, HOLD=1'b1);
  - default HOLD constant;
  - the 32-bit digit-word width constant, also used by the display driver.
- One natural sub-module, sseg_rr_pick: combinational, inputs vec[NREQ] and ptr; outputs valid and one-hot winner.
- Owner index encode and data mux stay in sseg_arb.

Test Plan (NREQ=4, HOLD=4):
1. Reset priority: rst=1 for 2 cycles with req=4'hf → gnt=0, en=0, dat=0 throughout. First edge after rst deasserts → gnt=4'b0001, en=1.
2. Single requester: req=4'b0100, dat_i[95:64]=32'hDEADBEEF, blink_i[2]=1 → one cycle later gnt=4'b0100, en=1, dat=32'hDEADBEEF, mod=1. Held for 20 cycles with no blank cycle.
3. Full rotation: req=4'hf from IDLE, ptr=0 → gnt follows 0001, 0010, 0100, 1000, 0001, each for exactly 4 cycles with no gaps.
4. Early release: req=4'b0011 and owner 0 drops req after 2 cycles → next edge gnt=0, en=0, dat=0 for 1 cycle. Following edge gnt=4'b0010.
5. Live passthrough: during owner 1 hold, change dat_i[63:32] from 32'h12345678 to 32'h0000ABCD → dat changes in the same cycle, gnt unchanged. Toggling blink_i[1] toggles mod in the same cycle.
6. Reset mid-operation: assert rst during the 2nd cycle of owner 3 hold → next edge gnt=0, en=0. After release with req=4'b1001 → gnt=4'b0001 because ptr was reset to 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display arbiter and driver.
package sseg_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } sseg_state_t;

    localparam int unsigned HOLD_DEFAULT = 100000000;
    localparam int unsigned DIGIT_W      = 32;

endpackage

// File: rtl/sseg_rr_pick.sv
// Round-robin picker: first set bit of vec scanning from ptr upward, wrapping modulo NREQ.
module sseg_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  vec,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [NREQ-1:0]  win
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!valid && vec[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_arb.sv
// Round-robin arbiter sharing one seven-segment display among NREQ sources with a minimum hold.
module sseg_arb
    import sseg_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned HOLD  = HOLD_DEFAULT,
    localparam int unsigned CNT_W = $clog2(HOLD),
    localparam int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [DIGIT_W*NREQ-1:0] dat_i,
    input  logic [NREQ-1:0]         blink_i,
    output logic [NREQ-1:0]         gnt,
    output logic                    en,
    output logic                    mod,
    output logic [DIGIT_W-1:0]      dat
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

    sseg_state_t      state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  cand;
    logic             pick_valid;
    logic [NREQ-1:0]  pick_win;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] own_idx;

    // In HOLD only the other waiters compete; the owner is excluded.
    assign cand = (state == StIdle) ? req : (req & ~gnt);

    sseg_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .vec   (cand),
        .ptr   (ptr),
        .valid (pick_valid),
        .win   (pick_win)
    );

    always_comb begin
        win_idx = '0;
        own_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_win[k]) win_idx = PTR_W'(k);
            if (gnt[k])      own_idx = PTR_W'(k);
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (pick_valid) begin
                        gnt   <= pick_win;
                        ptr   <= ptr_nxt;
                        cnt   <= RELOAD;
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (!(|(req & gnt))) begin
                        gnt   <= '0;
                        state <= StIdle;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pick_valid) begin
                        gnt <= pick_win;
                        ptr <= ptr_nxt;
                        cnt <= RELOAD;
                    end else begin
                        cnt <= RELOAD;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

    assign en = |gnt;

    always_comb begin
        dat = '0;
        mod = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && own_idx == PTR_W'(k)) begin
                dat = dat_i[k*DIGIT_W +: DIGIT_W];
                mod = blink_i[k];
            end
        end
    end

endmodule

// File: tb/tb_sseg_arb.sv
// Directed bench for sseg_arb with NREQ=4, HOLD=4.
module tb_sseg_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] dat_i;
    logic [3:0]   blink_i;
    logic [3:0]   gnt;
    logic         en;
    logic         mod;
    logic [31:0]  dat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sseg_arb #(
        .NREQ (4),
        .HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dat_i   (dat_i),
        .blink_i (blink_i),
        .gnt     (gnt),
        .en      (en),
        .mod     (mod),
        .dat     (dat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'h0;
        dat_i   = '0;
        blink_i = 4'h0;

        // Reset wins over pending requests
        req = 4'hf;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_en", 32'(en), 32'h0);
            check("rst_dat", dat, 32'h0);
        end
        rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        check("post_rst_en", 32'(en), 32'h1);
        req = 4'h0;
        step();
        check("drop_gnt", 32'(gnt), 32'h0);

        // Single requester with data and blink
        req            = 4'b0100;
        dat_i[95:64]   = 32'hDEADBEEF;
        blink_i[2]     = 1'b1;
        step();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_en", 32'(en), 32'h1);
        check("single_dat", dat, 32'hDEADBEEF);
        check("single_mod", 32'(mod), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("single_hold_gnt", 32'(gnt), 32'h4);
        end
        req = 4'h0;
        step();
        check("single_release", 32'(gnt), 32'h0);

        // Full rotation from ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rot_idle", 32'(gnt), 32'h0);
        req = 4'hf;
        step();
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 4; c++) begin
                check("rot_gnt", 32'(gnt), 32'(4'b0001 << (t % 4)));
                check("rot_en", 32'(en), 32'h1);
                step();
            end
        end
        check("rot_next", 32'(gnt), 32'h2);
        req = 4'h0;
        step();
        check("rot_release", 32'(gnt), 32'h0);

        // Early release leaves one blank cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req = 4'b0011;
        step();
        check("early_gnt0", 32'(gnt), 32'h1);
        step();
        check("early_gnt0_hold", 32'(gnt), 32'h1);
        req = 4'b0010;
        step();
        check("early_blank_gnt", 32'(gnt), 32'h0);
        check("early_blank_en", 32'(en), 32'h0);
        check("early_blank_dat", dat, 32'h0);
        check("early_blank_mod", 32'(mod), 32'h0);
        step();
        check("early_gnt1", 32'(gnt), 32'h2);

        // Live passthrough of owner data and blink
        dat_i[63:32] = 32'h12345678;
        #1;
        check("pass_dat_a", dat, 32'h12345678);
        dat_i[63:32] = 32'h0000ABCD;
        #1;
        check("pass_dat_b", dat, 32'h0000ABCD);
        check("pass_gnt", 32'(gnt), 32'h2);
        blink_i[1] = 1'b1;
        #1;
        check("pass_mod_on", 32'(mod), 32'h1);
        blink_i[1] = 1'b0;
        #1;
        check("pass_mod_off", 32'(mod), 32'h0);

        // Reset in the middle of owner 3's hold
        req              = 4'b1000;
        dat_i[127:96]    = 32'hCAFEF00D;
        step();
        check("r3_blank", 32'(gnt), 32'h0);
        step();
        check("r3_gnt_c1", 32'(gnt), 32'h8);
        check("r3_dat", dat, 32'hCAFEF00D);
        step();
        check("r3_gnt_c2", 32'(gnt), 32'h8);
        rst = 1'b1;
        step();
        check("r3_rst_gnt", 32'(gnt), 32'h0);
        check("r3_rst_en", 32'(en), 32'h0);
        rst = 1'b0;
        req = 4'b1001;
        step();
        check("r3_after_gnt", 32'(gnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
